// File: rtl/pipeline_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl_pkg
//   Shared definitions for the pipeline hazard/stall control slice: the
//   sequencer state encoding, the default register-address width and the
//   grouped stage-control word with its fixed decode patterns. The ID/EX
//   register and the bubble mux import this package as well.
// -----------------------------------------------------------------------------
package pipeline_stall_ctrl_pkg;

  // Sequencer state: normal flow or MUL/DIV executing.
  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MDU = 1'b1
  } state_e;

  localparam int REG_AW_DEF  = 5;
  localparam int MDU_LAT_DEF = 4;
  localparam int CNT_W_DEF   = 4;

  // Stage enables / clears that leave the sequencer together.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic back_we;
  } stage_ctrl_t;

  // Reset: front end closed, IF/ID cleared, ID/EX fed zeros, back end held.
  localparam stage_ctrl_t CTRL_RESET  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
                                          idex_bubble: 1'b1, back_we: 1'b0};
  // Data-memory wait: every register holds, nothing is cleared.
  localparam stage_ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                          idex_bubble: 1'b0, back_we: 1'b0};
  // Front end held, bubble inserted, back end drains (load-use and MDU busy).
  localparam stage_ctrl_t CTRL_HOLD   = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                          idex_bubble: 1'b1, back_we: 1'b1};
  // Normal flow.
  localparam stage_ctrl_t CTRL_RUN    = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                          idex_bubble: 1'b0, back_we: 1'b1};

  // Load-use hazard: a load in ID/EX writes a register the ID instruction reads.
  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  function automatic logic is_load_use(input logic             memread,
                                       input logic [REG_AW_DEF-1:0] ex_rt,
                                       input logic [REG_AW_DEF-1:0] id_rs,
                                       input logic [REG_AW_DEF-1:0] id_rt);
    return memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_mdu_countdown.sv
// -----------------------------------------------------------------------------
// mdu_countdown
//   Counts down the remaining MUL/DIV execution cycles. Loaded on issue,
//   decremented on every enabled cycle until it reaches zero, and flags the
//   final MDU cycle.
// Ports
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-low reset, clears the count
//   load      load load_val this cycle (issue)
//   load_val  cycles to run after the issue cycle
//   en        count enable (low while data memory stalls)
//   last      count==1: this is the final MDU cycle
// -----------------------------------------------------------------------------
module mdu_countdown #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Merges data-memory
//   wait, MUL/DIV busy, load-use hazards, MUL/DIV issue and taken branches into
//   one set of stage enables, flushes and bubble selects. Outputs are decoded
//   combinationally from the state, the MDU countdown and the inputs.
//
// Parameters
//   REG_AW   register-address width
//   MDU_LAT  MUL/DIV execution cycles (2..15)
//   CNT_W    countdown width, must hold MDU_LAT-1
//
// Ports
//   clk_i, rst_i            clock / asynchronous active-low reset
//   ex_memread_i, ex_rt_i   load in ID/EX and its destination
//   id_rs_i, id_rt_i        IF/ID source registers
//   branch_taken_i          ID-stage branch/jump taken
//   mdu_start_i             MUL/DIV ready to issue from ID
//   dmem_stall_i            data memory not ready
//   pc_we_o, ifid_we_o      front-end write enables
//   ifid_flush_o            IF/ID clear to NOP
//   idex_bubble_o           ID/EX control mux selects zeros
//   back_we_o               ID/EX, EX/MEM, MEM/WB write enable
//   mdu_busy_o, mdu_done_o  MUL/DIV executing / last-cycle pulse
//
// Configuration
//   HAZARD_PERF_CNT_EN  adds stall_cyc_o (cycles with pc_we_o low) and
//                       flush_cnt_o (cycles with ifid_flush_o high), 32-bit
//                       wrapping counters.
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              branch_taken_i,
  input  logic              mdu_start_i,
  input  logic              dmem_stall_i,
  output logic              pc_we_o,
  output logic              ifid_we_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              back_we_o,
  output logic              mdu_busy_o,
  output logic              mdu_done_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cyc_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  state_e      state;
  stage_ctrl_t ctrl;
  logic        load_use;
  logic        mdu_issue;
  logic        mdu_last;

  assign load_use = ex_memread_i && (ex_rt_i != '0) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

  // Issue only from RUN when the pipe moves and no load-use bubble is pending;
  // a rejected start simply retries next cycle.
  assign mdu_issue = (state == ST_RUN) && !dmem_stall_i && !load_use && mdu_start_i;

  mdu_countdown #(
    .CNT_W (CNT_W)
  ) u_mdu_countdown (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (mdu_issue),
    .load_val (CNT_W'(MDU_LAT - 1)),
    .en       (!dmem_stall_i),
    .last     (mdu_last)
  );

  // Data-memory wait freezes the sequencer along with the rest of the pipe.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_RUN;
    end else if (!dmem_stall_i) begin
      case (state)
        ST_RUN:  if (mdu_issue) state <= ST_MDU;
        ST_MDU:  if (mdu_last)  state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

  // Priority: reset > dmem wait > MDU busy > load-use > issue/branch/normal.
  // Reset is applied here as well so the outputs take their safe values the
  // moment rst_i falls, without waiting for a clock.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the decode leaves a signal unassigned and infers a latch.
    ctrl       = CTRL_RUN;
    mdu_busy_o = 1'b0;
    mdu_done_o = 1'b0;
    if (!rst_i) begin
      ctrl = CTRL_RESET;
    end else if (dmem_stall_i) begin
      ctrl       = CTRL_FREEZE;
      mdu_busy_o = (state == ST_MDU);
    end else if (state == ST_MDU) begin
      ctrl       = CTRL_HOLD;
      mdu_busy_o = 1'b1;
      mdu_done_o = mdu_last;
    end else if (load_use) begin
      // Taken branch is ignored here; it re-resolves after the bubble.
      ctrl = CTRL_HOLD;
    end else begin
      // Issue leaves all enables high; a taken branch in the same cycle
      // additionally clears the wrong-path fetch.
      ctrl            = CTRL_RUN;
      ctrl.ifid_flush = branch_taken_i;
    end
  end

  assign pc_we_o       = ctrl.pc_we;
  assign ifid_we_o     = ctrl.ifid_we;
  assign ifid_flush_o  = ctrl.ifid_flush;
  assign idex_bubble_o = ctrl.idex_bubble;
  assign back_we_o     = ctrl.back_we;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cyc_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_we_o)     stall_cyc_o <= stall_cyc_o + 32'd1;
      if (ifid_flush_o) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//   Self-checking bench for pipeline_stall_ctrl. A behavioural model tracks the
//   number of MUL/DIV cycles still outstanding and derives the expected
//   stage controls from the hazard priority rules. Directed scenarios cover
//   reset, load-use, MDU issue with and without memory wait, branch vs.
//   load-use and reset during MDU; a randomized run follows. Build with
//   +define+HAZARD_PERF_CNT_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mr = 1'b0;
  logic [REG_AW-1:0] ert = '0;
  logic [REG_AW-1:0] irs = '0;
  logic [REG_AW-1:0] irt = '0;
  logic              br = 1'b0;
  logic              st = 1'b0;
  logic              dm = 1'b0;

  logic pc_we, ifid_we, ifid_flush, idex_bubble, back_we, mdu_busy, mdu_done;
  logic [6:0] obs;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cyc, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: MDU cycles still to run, and reference perf counts.
  int          rem = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .ex_memread_i   (mr),
    .ex_rt_i        (ert),
    .id_rs_i        (irs),
    .id_rt_i        (irt),
    .branch_taken_i (br),
    .mdu_start_i    (st),
    .dmem_stall_i   (dm),
    .pc_we_o        (pc_we),
    .ifid_we_o      (ifid_we),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .back_we_o      (back_we),
    .mdu_busy_o     (mdu_busy),
    .mdu_done_o     (mdu_done)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cyc_o    (stall_cyc),
    .flush_cnt_o    (flush_cnt)
`endif
  );

  // Packed view: {pc_we, ifid_we, flush, bubble, back_we, busy, done}
  assign obs = {pc_we, ifid_we, ifid_flush, idex_bubble, back_we, mdu_busy, mdu_done};

  function automatic logic model_lu();
    return mr && (ert != 0) && ((ert == irs) || (ert == irt));
  endfunction

  function automatic logic [6:0] model_out();
    if (!rst_n)    return 7'b0011000;
    if (dm)        return {5'b00000, (rem > 0), 1'b0};
    if (rem > 0)   return {5'b00011, 1'b1, (rem == 1)};
    if (model_lu()) return 7'b0001100;
    return {2'b11, br, 2'b01, 2'b00};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     = 0;
      m_stall = '0;
      m_flush = '0;
    end else begin
      logic [6:0] e;
      e = model_out();
      if (!e[6]) m_stall = m_stall + 32'd1;
      if (e[4])  m_flush = m_flush + 32'd1;
      if (!dm) begin
        if (rem > 0)                rem = rem - 1;
        else if (!model_lu() && st) rem = MDU_LAT - 1;
      end
    end
  end

  // Apply one cycle of inputs after the falling edge; outputs settle by +1.
  task automatic drive(input logic a_mr, input logic [REG_AW-1:0] a_ert,
                       input logic [REG_AW-1:0] a_irs, input logic [REG_AW-1:0] a_irt,
                       input logic a_br, input logic a_st, input logic a_dm);
    @(negedge clk);
    mr = a_mr; ert = a_ert; irs = a_irs; irt = a_irt;
    br = a_br; st = a_st; dm = a_dm;
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (obs !== 7'b0011000 || obs !== model_out()) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", obs, 7'b0011000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b1100100) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected %b", obs, 7'b1100100);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc_we !== 1'b0 || idex_bubble !== 1'b1 || obs !== model_out()) begin
      errors++;
      $display("FAIL load_use_stall: got %b expected %b", obs, model_out());
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL load_use_one_cycle: got %b expected %b", obs, 7'b1100100);
    end
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc_we !== 1'b1 || obs !== 7'b1100100) begin
      errors++;
      $display("FAIL load_use_r0: got %b expected %b", obs, 7'b1100100);
    end
  endtask

  // Issue an MDU op, optionally with a memory wait on MDU cycles 2 and 3,
  // and count busy cycles until the sequencer is back in RUN.
  task automatic run_mdu(input bit with_stall, input int exp_cycles, input string name);
    int n = 0;
    int done_at = 0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== 7'b1100100) begin
      errors++;
      $display("FAIL %s_issue: got %b expected %b", name, obs, 7'b1100100);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, with_stall && (i == 1 || i == 2));
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL %s_cycle%0d: got %b expected %b", name, i, obs, model_out());
      end
      if (!mdu_busy) break;
      n++;
      if (mdu_done) done_at = n;
    end
    checks++;
    if (n != exp_cycles || done_at != exp_cycles) begin
      errors++;
      $display("FAIL %s_length: busy %0d done_at %0d expected %0d", name, n, done_at, exp_cycles);
    end
  endtask

  task automatic test_mdu();
    run_mdu(1'b0, MDU_LAT - 1, "mdu");
  endtask

  task automatic test_mdu_stall();
    run_mdu(1'b1, MDU_LAT + 1, "mdu_stall");
  endtask

  task automatic test_branch();
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ifid_flush !== 1'b0 || pc_we !== 1'b0 || obs !== model_out()) begin
      errors++;
      $display("FAIL branch_vs_load_use: got %b expected %b", obs, 7'b0001100);
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ifid_flush !== 1'b1 || pc_we !== 1'b1 || obs !== model_out()) begin
      errors++;
      $display("FAIL branch_flush: got %b expected %b", obs, 7'b1110100);
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== 7'b1110100) begin
      errors++;
      $display("FAIL branch_with_issue: got %b expected %b", obs, 7'b1110100);
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mdu_busy !== 1'b1 || obs !== model_out()) begin
      errors++;
      $display("FAIL branch_issue_busy: got %b expected %b", obs, model_out());
    end
    for (int i = 0; i < MDU_LAT; i++) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_mdu();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (mdu_busy !== 1'b1 || rem != 2) begin
      errors++;
      $display("FAIL rst_mdu_setup: busy %b model_rem %0d expected busy 1 rem 2", mdu_busy, rem);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0011000) begin
      errors++;
      $display("FAIL rst_mdu_immediate: got %b expected %b", obs, 7'b0011000);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (mdu_done !== 1'b0 || obs !== 7'b0011000) begin
        errors++;
        $display("FAIL rst_mdu_hold%0d: got %b expected %b", i, obs, 7'b0011000);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b1100100) begin
      errors++;
      $display("FAIL rst_mdu_release: got %b expected %b", obs, 7'b1100100);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) == 0, REG_AW'($urandom_range(0, 3)),
            REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0);
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL random_cycle%0d: got %b expected %b", i, obs, model_out());
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_cyc !== m_stall || flush_cnt !== m_flush) begin
        errors++;
        $display("FAIL random_perf%0d: got %0d/%0d expected %0d/%0d",
                 i, stall_cyc, flush_cnt, m_stall, m_flush);
      end
`endif
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (stall_cyc !== 32'd1 || flush_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_counts: got %0d/%0d expected 1/1", stall_cyc, flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_mdu();
    test_mdu_stall();
    test_branch();
    test_reset_mid_mdu();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
